trigger_sequencer: RTL and testbench
====================================

# trigger_sequencer

- Controller for the trigger pattern path.
- Accepts a pattern configuration through a valid/ready handshake and holds it armed.
- On a trigger pulse, plays the pattern out serially, LSB first, on an inverted output line. Each bit lasts a programmable number of clock cycles, and the whole pattern repeats a programmable number of times.
- Sits between the configuration/register interface and the physical trigger output; wraps the circular pattern shifter and sequences its load and shift operations.

## Interface
- WIDTH, 10: pattern length in bits.
- CNT_W, 8: repeat-count width.
- DIV_W, 16: bit-period divider width.

Ports:
- clk  in  1  sole clock; all logic on rising edge.
- reset_n  in  1  synchronous, active-low reset.
- cfg_valid  in  1  configuration offered.
- cfg_ready  out  1  configuration can be accepted; combinational.
- cfg_pattern  in  WIDTH  pattern bits, bit 0 played first.
- cfg_repeat  in  CNT_W  number of plays is cfg_repeat+1.
- cfg_div  in  DIV_W  each bit is held for cfg_div+1 cycles.
- trig  in  1  single-cycle start pulse, synchronous to clk.
- abort  in  1  stop immediately and discard the configuration.
- busy  out  1  high in RUN.
- done  out  1  one-cycle pulse at normal completion.
- bit_strobe  out  1  high on the first cycle of every bit.
- data_out  out  1  serial output, inverted: line = ~bit; idle level 1.

## Operation
States:
- IDLE: no configuration held.
- ARMED: configuration held, waiting for a trigger.
- RUN: pattern playing.
- DONE: one-cycle completion state.

Transitions:
- IDLE -> ARMED on cfg_valid && cfg_ready. The pattern, repeat count and divider are captured into registers.
- ARMED -> ARMED on a new handshake; the new configuration overwrites the old one.
- ARMED -> RUN on trig. The shifter loads the stored pattern, the divider counter clears, the bit index goes to 0 and the repeat counter loads cfg_repeat.
- RUN, divider at cfg_div: advance to the next bit (circular shift). After bit WIDTH-1:
  - if the repeat counter is nonzero, decrement it and continue from bit 0 with no gap;
  - if it is zero, go to DONE.
- DONE -> ARMED unconditionally. The configuration is retained, so a later trig replays the same pattern.
- abort in ARMED, RUN or DONE -> IDLE. No done pulse. abort in IDLE is a no-op.

Handshake and priority rules:
- cfg_ready = reset_n && (IDLE || (ARMED && !trig && !abort)). It is 0 in RUN and DONE.
- Priority, highest first: reset_n, abort, trig, cfg handshake.
- trig in IDLE, RUN or DONE is ignored.
- Edge cases:
  - cfg_div = 0 gives one cycle per bit.
  - cfg_repeat = 0 gives a single play.
  - The divider comparison is unsigned and covers the full DIV_W range.

## Timing
- All outputs are registered except cfg_ready.
- Reset values: state IDLE, busy 0, done 0, bit_strobe 0, data_out 1, all counters 0, stored configuration 0. cfg_ready is 0 while reset_n is low.
- Start latency: trig sampled high at edge t → from edge t+1:
  - busy = 1;
  - bit_strobe = 1;
  - data_out = ~pattern[0].
- Each bit occupies exactly cfg_div+1 cycles. The RUN length is (cfg_repeat+1)·WIDTH·(cfg_div+1) cycles.
- On the cycle after the last bit:
  - state DONE, done = 1, busy = 0, data_out = 1;
  - the following cycle returns to ARMED.
- Abort sampled at edge t → at t+1: busy 0, data_out 1, bit_strobe 0, cfg_ready 1.
- Reset mid-RUN takes effect at the next edge, with the same outputs as abort. The configuration is also cleared.

## Structure
- Shared package holds:
  - a state enum with IDLE, ARMED, RUN, DONE;
  - the default values of WIDTH, CNT_W and DIV_W;
  - the IDLE_LEVEL constant (1).
- One sub-module, pattern_shifter:
  - WIDTH-bit circular right shift with a synchronous load and a shift enable;
  - exposes bit 0;
  - the inversion happens in the output register of trigger_sequencer.
- The divider counter, bit index ($clog2(WIDTH) bits) and repeat counter live in trigger_sequencer.

## Test plan
- Single play: reset; cfg pattern 10'b1010011001, repeat 0, div 0; trig.
  - data_out over 10 cycles is 0,1,1,0,0,1,1,0,1,0;
  - bit_strobe is high on all 10 cycles;
  - done is pulsed at cycle 11, then the block is ARMED with cfg_ready 1.
- Divider and repeat: pattern 10'h3FF, div 2, repeat 2; trig.
  - busy high for exactly 90 cycles;
  - 30 bit_strobe pulses, spaced 3 cycles apart;
  - data_out 0 throughout;
  - exactly one done pulse.
- Abort: abort on the 3rd cycle of bit 4 (div 3).
  - Next cycle: busy 0, data_out 1, no done, cfg_ready 1.
  - A following trig is ignored (IDLE).
- Simultaneous events in ARMED:
  - trig with cfg_valid: cfg_ready is 0 and the old pattern plays.
  - abort with trig: the block goes to IDLE.
  - trig during RUN: no restart; total length unchanged.
- Reset mid-run: reset_n low for 1 cycle during bit 6.
  - All outputs take reset values at the next edge.
  - trig without a new config is ignored.
  - A new config followed by trig plays correctly.
- Replay: after done, trig again without reconfiguring; the identical sequence is reproduced.

Source files
------------

// File: rtl/trigger_sequencer_pkg.sv
// Shared types and constants for the trigger pattern path.
package trigger_sequencer_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    RUN   = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int DEF_WIDTH = 10;
  localparam int DEF_CNT_W = 8;
  localparam int DEF_DIV_W = 16;

  localparam logic IDLE_LEVEL = 1'b1;

endpackage

// File: rtl/trigger_sequencer_pattern_shifter.sv
// Circular right shifter holding the trigger pattern; bit 0 is the next bit out.
module pattern_shifter
  import trigger_sequencer_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             shift,
  output logic             lsb
);

  logic [WIDTH-1:0] q;

  // Load takes precedence over shift.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      q <= '0;
    end else if (load) begin
      q <= load_value;
    end else if (shift) begin
      q <= {q[0], q[WIDTH-1:1]};
    end else begin
      q <= q;
    end
  end

  assign lsb = q[0];

endmodule

// File: rtl/trigger_sequencer.sv
// Trigger pattern controller: holds an armed configuration and plays it out
// serially, LSB first and inverted, on each trigger.
module trigger_sequencer
  import trigger_sequencer_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = DEF_CNT_W,
  parameter int DIV_W = DEF_DIV_W
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [WIDTH-1:0] cfg_pattern,
  input  logic [CNT_W-1:0] cfg_repeat,
  input  logic [DIV_W-1:0] cfg_div,
  input  logic             trig,
  input  logic             abort,
  output logic             busy,
  output logic             done,
  output logic             bit_strobe,
  output logic             data_out
);

  localparam int IDX_W = $clog2(WIDTH);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH - 1);

  state_t           state;
  logic [WIDTH-1:0] pat_reg;
  logic [CNT_W-1:0] rep_reg;
  logic [DIV_W-1:0] div_reg;
  logic [DIV_W-1:0] div_cnt;
  logic [IDX_W-1:0] bit_idx;
  logic [CNT_W-1:0] rep_cnt;

  logic div_end;
  logic last_bit;
  logic finish;
  logic load;
  logic shift;
  logic next_bit;

  assign div_end  = (div_cnt == div_reg);
  assign last_bit = (bit_idx == LAST_IDX);
  assign finish   = div_end && last_bit && (rep_cnt == '0);

  // The shifter runs one bit ahead of data_out: it is loaded pre-rotated so
  // its lsb is always the bit the output register takes at the next advance.
  assign load  = (state == ARMED) && trig && !abort;
  assign shift = (state == RUN) && div_end && !finish && !abort;

  assign cfg_ready = reset_n &&
                     ((state == IDLE) || ((state == ARMED) && !trig && !abort));

  pattern_shifter #(.WIDTH(WIDTH)) u_shifter (
    .clk        (clk),
    .reset_n    (reset_n),
    .load       (load),
    .load_value ({pat_reg[0], pat_reg[WIDTH-1:1]}),
    .shift      (shift),
    .lsb        (next_bit)
  );

  // Sequencer state, counters, stored configuration and registered outputs.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state      <= IDLE;
      pat_reg    <= '0;
      rep_reg    <= '0;
      div_reg    <= '0;
      div_cnt    <= '0;
      bit_idx    <= '0;
      rep_cnt    <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      bit_strobe <= 1'b0;
      data_out   <= IDLE_LEVEL;
    end else if (abort && (state != IDLE)) begin
      state      <= IDLE;
      pat_reg    <= '0;
      rep_reg    <= '0;
      div_reg    <= '0;
      div_cnt    <= '0;
      bit_idx    <= '0;
      rep_cnt    <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      bit_strobe <= 1'b0;
      data_out   <= IDLE_LEVEL;
    end else begin
      case (state)
        IDLE: begin
          if (cfg_valid) begin
            pat_reg <= cfg_pattern;
            rep_reg <= cfg_repeat;
            div_reg <= cfg_div;
            state   <= ARMED;
          end else begin
            state <= IDLE;
          end
        end
        ARMED: begin
          if (trig) begin
            state      <= RUN;
            div_cnt    <= '0;
            bit_idx    <= '0;
            rep_cnt    <= rep_reg;
            busy       <= 1'b1;
            bit_strobe <= 1'b1;
            data_out   <= ~pat_reg[0];
          end else if (cfg_valid) begin
            pat_reg <= cfg_pattern;
            rep_reg <= cfg_repeat;
            div_reg <= cfg_div;
          end else begin
            state <= ARMED;
          end
        end
        RUN: begin
          if (div_end) begin
            div_cnt <= '0;
            if (finish) begin
              state      <= DONE;
              busy       <= 1'b0;
              done       <= 1'b1;
              bit_strobe <= 1'b0;
              data_out   <= IDLE_LEVEL;
            end else begin
              bit_strobe <= 1'b1;
              data_out   <= ~next_bit;
              if (last_bit) begin
                bit_idx <= '0;
                rep_cnt <= rep_cnt - {{(CNT_W-1){1'b0}}, 1'b1};
              end else begin
                bit_idx <= bit_idx + {{(IDX_W-1){1'b0}}, 1'b1};
              end
            end
          end else begin
            div_cnt    <= div_cnt + {{(DIV_W-1){1'b0}}, 1'b1};
            bit_strobe <= 1'b0;
          end
        end
        DONE: begin
          state <= ARMED;
          done  <= 1'b0;
        end
        default: begin
          state      <= IDLE;
          busy       <= 1'b0;
          done       <= 1'b0;
          bit_strobe <= 1'b0;
          data_out   <= IDLE_LEVEL;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_trigger_sequencer.sv
// Scoreboard bench for trigger_sequencer: a pattern-level model predicts each
// output cycle and a monitor compares whatever the DUT presents.
module tb_trigger_sequencer;

  logic        clk;
  logic        reset_n;
  logic        cfg_valid;
  logic        cfg_ready;
  logic [9:0]  cfg_pattern;
  logic [7:0]  cfg_repeat;
  logic [15:0] cfg_div;
  logic        trig;
  logic        abort;
  logic        busy;
  logic        done;
  logic        bit_strobe;
  logic        data_out;

  trigger_sequencer dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .cfg_valid   (cfg_valid),
    .cfg_ready   (cfg_ready),
    .cfg_pattern (cfg_pattern),
    .cfg_repeat  (cfg_repeat),
    .cfg_div     (cfg_div),
    .trig        (trig),
    .abort       (abort),
    .busy        (busy),
    .done        (done),
    .bit_strobe  (bit_strobe),
    .data_out    (data_out)
  );

  typedef struct {
    int   cyc;
    logic busy;
    logic done;
    logic strobe;
    logic data;
  } exp_t;

  exp_t q[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   cyc = 0;
  bit   mon_en = 0;

  // Reference model: configuration held or not, plus last cycle of a play.
  bit         held = 0;
  logic [9:0] m_pat = '0;
  int         m_rep = 0;
  int         m_div = 0;
  int         busy_until = -1;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Monitor: one sample per cycle, 1 time unit after the rising edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      cyc++;
      #1;
      if (mon_en) begin
        n_vec++;
        if (busy || done || bit_strobe) begin
          if (q.size() == 0) begin
            n_err++;
            $display("FAIL unexpected_output cyc=%0d got busy=%b done=%b strobe=%b data=%b, want no activity",
                     cyc, busy, done, bit_strobe, data_out);
          end else begin
            e = q.pop_front();
            if (e.cyc != cyc || e.busy !== busy || e.done !== done ||
                e.strobe !== bit_strobe || e.data !== data_out) begin
              n_err++;
              $display("FAIL output cyc=%0d got busy=%b done=%b strobe=%b data=%b, want cyc=%0d busy=%b done=%b strobe=%b data=%b",
                       cyc, busy, done, bit_strobe, data_out, e.cyc, e.busy, e.done, e.strobe, e.data);
            end
          end
        end else if (q.size() > 0 && q[0].cyc <= cyc) begin
          e = q.pop_front();
          n_err++;
          $display("FAIL missing_output cyc=%0d got busy=%b done=%b strobe=%b data=%b, want busy=%b done=%b strobe=%b data=%b",
                   cyc, busy, done, bit_strobe, data_out, e.busy, e.done, e.strobe, e.data);
        end else if (data_out !== 1'b1) begin
          n_err++;
          $display("FAIL idle_level cyc=%0d got data_out=%b, want 1", cyc, data_out);
        end
      end
    end
  end

  task automatic push_play(input int base);
    exp_t e;
    int   len;
    len = (m_rep + 1) * 10 * (m_div + 1);
    for (int k = 0; k < len; k++) begin
      e.cyc    = base + 1 + k;
      e.busy   = 1'b1;
      e.done   = 1'b0;
      e.strobe = ((k % (m_div + 1)) == 0);
      e.data   = ~m_pat[(k / (m_div + 1)) % 10];
      q.push_back(e);
    end
    e.cyc    = base + len + 1;
    e.busy   = 1'b0;
    e.done   = 1'b1;
    e.strobe = 1'b0;
    e.data   = 1'b1;
    q.push_back(e);
    busy_until = base + len + 1;
  endtask

  // Drive one cycle of inputs, check cfg_ready, then update the model.
  task automatic step(input logic v, input logic [9:0] p, input logic [7:0] r,
                      input logic [15:0] d, input logic t, input logic a, input logic rn);
    int   m;
    bit   running;
    logic exp_ready;
    @(negedge clk);
    cfg_valid   = v;
    cfg_pattern = p;
    cfg_repeat  = r;
    cfg_div     = d;
    trig        = t;
    abort       = a;
    reset_n     = rn;
    #1;
    m         = cyc;
    running   = held && (m <= busy_until);
    exp_ready = rn && (!held || (!running && !t && !a));
    if (mon_en) begin
      n_vec++;
      if (cfg_ready !== exp_ready) begin
        n_err++;
        $display("FAIL cfg_ready cyc=%0d got %b, want %b", m, cfg_ready, exp_ready);
      end
    end
    if (!rn || (a && held)) begin
      held = 0;
      q.delete();
      busy_until = m;
    end else if (t && held && !running) begin
      push_play(m);
    end else if (v && exp_ready) begin
      held  = 1;
      m_pat = p;
      m_rep = int'(r);
      m_div = int'(d);
    end
  endtask

  task automatic do_idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 10'h0, 8'h0, 16'h0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic do_cfg(input logic [9:0] p, input logic [7:0] r, input logic [15:0] d);
    step(1'b1, p, r, d, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic do_trig();
    step(1'b0, 10'h0, 8'h0, 16'h0, 1'b1, 1'b0, 1'b1);
  endtask

  task automatic do_abort();
    step(1'b0, 10'h0, 8'h0, 16'h0, 1'b0, 1'b1, 1'b1);
  endtask

  task automatic wait_play();
    while (held && cyc <= busy_until) do_idle(1);
    do_idle(1);
  endtask

  initial begin
    int op;
    cfg_valid = 1'b0; cfg_pattern = '0; cfg_repeat = '0; cfg_div = '0;
    trig = 1'b0; abort = 1'b0; reset_n = 1'b0;
    repeat (2) step(1'b0, 10'h0, 8'h0, 16'h0, 1'b0, 1'b0, 1'b0);
    mon_en = 1;
    do_idle(1);
    n_vec++;
    if (busy !== 1'b0 || done !== 1'b0 || bit_strobe !== 1'b0 || data_out !== 1'b1) begin
      n_err++;
      $display("FAIL reset_state got busy=%b done=%b strobe=%b data=%b, want 0 0 0 1",
               busy, done, bit_strobe, data_out);
    end

    // Single play, then replay of the same configuration.
    do_cfg(10'b1010011001, 8'd0, 16'd0);
    do_trig();
    wait_play();
    do_trig();
    wait_play();

    // Divider and repeat.
    do_cfg(10'h3FF, 8'd2, 16'd2);
    do_trig();
    wait_play();

    // Abort on the 3rd cycle of bit 4, then an ignored trigger.
    do_cfg(10'h2B5, 8'd0, 16'd3);
    do_trig();
    do_idle(18);
    do_abort();
    do_trig();
    do_idle(5);

    // Trigger together with a new configuration: old pattern plays.
    do_cfg(10'h0F3, 8'd0, 16'd0);
    step(1'b1, 10'h155, 8'd1, 16'd1, 1'b1, 1'b0, 1'b1);
    do_idle(3);
    do_trig();
    wait_play();
    // Abort with trigger in ARMED.
    step(1'b0, 10'h0, 8'h0, 16'h0, 1'b1, 1'b1, 1'b1);
    do_trig();
    do_idle(3);
    // Triggers during RUN do not restart.
    do_cfg(10'h1C7, 8'd1, 16'd1);
    do_trig();
    do_idle(5);
    do_trig();
    do_idle(7);
    do_trig();
    wait_play();

    // Reset during bit 6.
    do_cfg(10'h24E, 8'd0, 16'd1);
    do_trig();
    do_idle(12);
    step(1'b0, 10'h0, 8'h0, 16'h0, 1'b0, 1'b0, 1'b0);
    do_trig();
    do_idle(3);
    do_cfg(10'h31A, 8'd1, 16'd0);
    do_trig();
    wait_play();

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      op = $urandom_range(0, 99);
      if (op < 6)
        do_cfg(10'($urandom), 8'($urandom_range(0, 2)), 16'($urandom_range(0, 3)));
      else if (op < 12)
        do_trig();
      else if (op < 14)
        do_abort();
      else if (op < 15)
        step(1'b0, 10'h0, 8'h0, 16'h0, 1'b0, 1'b0, 1'b0);
      else if (op < 17)
        step(1'b1, 10'($urandom), 8'($urandom_range(0, 2)), 16'($urandom_range(0, 3)), 1'b1, 1'b0, 1'b1);
      else if (op < 18)
        step(1'b1, 10'($urandom), 8'd0, 16'd0, 1'b0, 1'b1, 1'b1);
      else
        do_idle(1);
    end
    wait_play();
    do_idle(2);

    n_vec++;
    if (q.size() != 0) begin
      n_err++;
      $display("FAIL scoreboard_drain got %0d pending entries, want 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
